// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and parity helper.
// The receiver imports this package as well.
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StRts,
      StBits,
      StAck,
      StWaitIdle,
      StFinish
   } ps2_state_e;

   localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
   localparam logic [7:0] PS2_CMD_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_ACK        = 8'hFA;

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a registered,
// one-cycle falling-edge strobe on the synchronized clock.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic ps2clk_in,
   input  logic ps2dat_in,
   output logic clk_s,
   output logic dat_s,
   output logic fall
);

   logic [1:0] clk_ff;
   logic [1:0] dat_ff;
   logic       clk_prev;

   // Idle bus is high, so the flops reset to 1 to avoid a spurious edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_ff   <= 2'b11;
         dat_ff   <= 2'b11;
         clk_prev <= 1'b1;
         fall     <= 1'b0;
      end else begin
         clk_ff   <= {clk_ff[0], ps2clk_in};
         dat_ff   <= {dat_ff[0], ps2dat_in};
         clk_prev <= clk_ff[1];
         fall     <= clk_prev & ~clk_ff[1];
      end
   end

   assign clk_s = clk_ff[1];
   assign dat_s = dat_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clock out
// start/data/parity/stop on device clock falls, then check the device ack.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 2500,
   parameter int unsigned TIMEOUT_CYCLES = 375000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       done,
   output logic       err,
   input  logic       ps2clk_in,
   input  logic       ps2dat_in,
   output logic       ps2clk_oe,
   output logic       ps2dat_oe
);

   localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   ps2_state_e    state_q, state_d;
   logic [8:0]    shift_q, shift_d;
   logic [IW-1:0] icnt_q, icnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [3:0]    bcnt_q, bcnt_d;
   logic          clk_oe_d, dat_oe_d, err_d;
   logic          clk_s, dat_s, fall;

   ps2_sync_edge u_sync (
      .clk       (clk),
      .reset     (reset),
      .ps2clk_in (ps2clk_in),
      .ps2dat_in (ps2dat_in),
      .clk_s     (clk_s),
      .dat_s     (dat_s),
      .fall      (fall)
   );

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      icnt_d   = icnt_q;
      tcnt_d   = tcnt_q;
      bcnt_d   = bcnt_q;
      clk_oe_d = ps2clk_oe;
      dat_oe_d = ps2dat_oe;
      err_d    = err;
      unique case (state_q)
         StIdle: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (tx_valid) begin
               shift_d  = {odd_parity(tx_data), tx_data};
               icnt_d   = '0;
               tcnt_d   = '0;
               bcnt_d   = '0;
               clk_oe_d = 1'b1;
               state_d  = StInhibit;
            end
         end
         StInhibit: begin
            if (icnt_q == INH_LAST) begin
               dat_oe_d = 1'b1;
               state_d  = StRts;
            end else begin
               icnt_d = icnt_q + IW'(1);
            end
         end
         StRts: begin
            // Data stays low as the start bit until the device's first fall.
            clk_oe_d = 1'b0;
            tcnt_d   = '0;
            state_d  = StBits;
         end
         StBits, StAck, StWaitIdle: begin
            if (tcnt_q == TMO_LAST) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               err_d    = 1'b1;
               state_d  = StFinish;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
               if (state_q == StBits) begin
                  if (fall) begin
                     if (bcnt_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                        state_d  = StAck;
                     end else begin
                        dat_oe_d = ~shift_q[0];
                        shift_d  = {1'b0, shift_q[8:1]};
                        bcnt_d   = bcnt_q + 4'd1;
                     end
                  end
               end else if (state_q == StAck) begin
                  if (fall) begin
                     if (dat_s) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                     end else begin
                        state_d = StWaitIdle;
                     end
                  end
               end else if (clk_s && dat_s) begin
                  err_d   = 1'b0;
                  state_d = StFinish;
               end
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         icnt_q    <= '0;
         tcnt_q    <= '0;
         bcnt_q    <= '0;
         ps2clk_oe <= 1'b0;
         ps2dat_oe <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         tx_busy   <= 1'b0;
         tx_ready  <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         icnt_q    <= icnt_d;
         tcnt_q    <= tcnt_d;
         bcnt_q    <= bcnt_d;
         ps2clk_oe <= clk_oe_d;
         ps2dat_oe <= dat_oe_d;
         done      <= (state_d == StFinish);
         err       <= err_d;
         tx_busy   <= (state_d != StIdle);
         tx_ready  <= (state_d == StIdle);
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device,
// random command bytes, timeout, missing ack, mid-frame reset and busy-time requests.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int unsigned INH = 20;
   localparam int unsigned TMO = 3000;
   localparam int          H   = 25;   // device clock half period in clk cycles

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx_busy, done, err;
   logic       ps2clk_oe, ps2dat_oe;
   logic       dev_clk_low, dev_dat_low;
   logic       clk_line, dat_line;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int done_cnt = 0;
   int fall11_cyc = 0;
   int run_len = 0;
   logic run_last_dat = 1'b0;

   assign clk_line = !(ps2clk_oe || dev_clk_low);
   assign dat_line = !(ps2dat_oe || dev_dat_low);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_busy   (tx_busy),
      .done      (done),
      .err       (err),
      .ps2clk_in (clk_line),
      .ps2dat_in (dat_line),
      .ps2clk_oe (ps2clk_oe),
      .ps2dat_oe (ps2dat_oe)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected wire bits: start, data LSB first, odd parity, stop.
   function automatic logic [10:0] exp_frame(input logic [7:0] b);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
      f[9]  = ($countones(b) % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (reset) begin
         run_len = 0;
      end else if (ps2clk_oe) begin
         run_len++;
         run_last_dat = ps2dat_oe;
      end else if (run_len != 0) begin
         check("clk_oe_len", run_len, INH + 1);
         check("rts_overlap", run_last_dat, 1'b1);
         run_len = 0;
      end
   end

   task automatic start_tx(input logic [7:0] b);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("accept_clk_oe", ps2clk_oe, 1'b1);
      check("accept_busy", {tx_ready, tx_busy}, 2'b01);
   endtask

   task automatic dev_run(input int n_edges, input bit do_ack,
                          output logic [10:0] bits, output bit ok);
      int t;
      bits = '1;
      ok   = 1'b0;
      t    = 0;
      while (!(clk_line && !dat_line)) begin
         @(negedge clk);
         t++;
         if (t > INH + 20) return;
      end
      ok = 1'b1;
      for (int k = 0; k < n_edges; k++) begin
         repeat (H) @(negedge clk);
         bits[k] = dat_line;
         if (k == 10 && do_ack) dev_dat_low = 1'b1;
         dev_clk_low = 1'b1;
         if (k == 10) fall11_cyc = cyc;
         repeat (H) @(negedge clk);
         dev_clk_low = 1'b0;
      end
      repeat (H) @(negedge clk);
      dev_dat_low = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit got, output logic e,
                            output int at);
      got = 1'b0;
      e   = 1'b0;
      at  = 0;
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            e   = err;
            at  = cyc;
            return;
         end
      end
   endtask

   task automatic send_frame(input string tag, input logic [7:0] b, input bit do_ack);
      logic [10:0] bits;
      bit          ok, got;
      logic        e;
      int          at;
      start_tx(b);
      fork
         dev_run(11, do_ack, bits, ok);
         wait_done(TMO + 200, got, e, at);
      join
      check({tag, "_rts_seen"}, ok, 1'b1);
      check({tag, "_bits"}, bits, exp_frame(b));
      check({tag, "_done"}, got, 1'b1);
      check({tag, "_err"}, e, !do_ack);
      if (!do_ack) check({tag, "_no_idle_wait"}, (at - fall11_cyc) <= 6, 1'b1);
   endtask

   initial begin
      logic [10:0] bits;
      bit          ok, got;
      logic        e;
      int          at, t_rel, base;

      reset = 1'b1;
      tx_valid = 1'b0;
      tx_data = '0;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputs", {tx_ready, tx_busy, done, err, ps2clk_oe, ps2dat_oe}, 6'b100000);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_outputs", {tx_ready, tx_busy, ps2clk_oe, ps2dat_oe}, 4'b1000);

      send_frame("setled", PS2_CMD_SETLED, 1'b1);
      send_frame("b01", 8'h01, 1'b1);
      send_frame("b00", 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) send_frame("rand", 8'($urandom_range(0, 255)), 1'b1);

      // Device never clocks: timeout measured from clock release.
      start_tx(PS2_CMD_ECHO);
      t_rel = -1;
      for (int t = 0; t < INH + 20; t++) begin
         @(negedge clk);
         if (!ps2clk_oe) begin
            t_rel = cyc;
            break;
         end
      end
      check("tmo_release", t_rel >= 0, 1'b1);
      wait_done(TMO + 50, got, e, at);
      check("tmo_done", got, 1'b1);
      check("tmo_latency", at - t_rel, TMO);
      check("tmo_err", e, 1'b1);
      check("tmo_oe", {ps2clk_oe, ps2dat_oe}, 2'b00);
      repeat (5) @(negedge clk);

      // Missing ack: data left high at the 11th fall.
      send_frame("nack", 8'hF3, 1'b0);
      repeat (2 * H) @(negedge clk);

      // Reset while data bit 4 is on the line.
      base = done_cnt;
      start_tx(8'hA5);
      dev_run(5, 1'b0, bits, ok);
      check("mid_bits", bits[4:0], exp_frame(8'hA5) & 11'h1F);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_state", {ps2clk_oe, ps2dat_oe, tx_ready, err}, 4'b0010);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("mid_rst_no_done", done_cnt - base, 0);
      send_frame("after_rst", PS2_CMD_RESET, 1'b1);

      // Reset and request together: reset wins.
      @(negedge clk);
      reset = 1'b1;
      tx_data = 8'h12;
      tx_valid = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tx_valid = 1'b0;
      @(negedge clk);
      check("rst_vs_valid", {tx_ready, ps2clk_oe}, 2'b10);

      // Request while busy is ignored.
      base = done_cnt;
      start_tx(8'h3C);
      fork
         dev_run(11, 1'b1, bits, ok);
         wait_done(TMO + 200, got, e, at);
         begin
            repeat (30) @(negedge clk);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            repeat (5) @(negedge clk);
            tx_valid = 1'b0;
         end
      join
      check("busy_bits", bits, exp_frame(8'h3C));
      check("busy_err", e, 1'b0);
      repeat (100) @(negedge clk);
      check("busy_single_done", done_cnt - base, 1);
      check("busy_idle_after", {tx_ready, tx_busy}, 2'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
